arbitro_mem_dados: RTL and testbench
====================================

# arbitro_mem_dados

Two-port arbiter and access sequencer for the 64-word data memory. It sits between the processor datapath (port 0) and the test/program loader (port 1) on one side and the data memory's single port (address, write data, write strobe, read strobe, read data) on the other. It grants one request at a time in round-robin order, drives the memory strobes for exactly one cycle per access, checks the address, and returns read data with a one-cycle acknowledge.

## Interface
- PALAVRAS, 64: memory depth in 32-bit words; valid word index is endereco>>2 < PALAVRAS
- LARGURA, 32: address and data width
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  access request, held until ackN
- esc0 / esc1  in  1  1 = write, 0 = read; stable while reqN high
- end0 / end1  in  LARGURA  byte address; stable while reqN high
- wdado0 / wdado1  in  LARGURA  write data; stable while reqN high
- ack0 / ack1  out  1  one-cycle completion pulse
- erro0 / erro1  out  1  valid only with ackN; 1 = rejected, no memory access
- rdado0 / rdado1  out  LARGURA  read result, valid with ackN, held until next ack on the same port
- mem_endereco  out  LARGURA  to memory address
- mem_valor  out  LARGURA  to memory write data
- mem_escrita  out  1  memory write strobe
- mem_leitura  out  1  memory read strobe
- mem_dado  in  LARGURA  memory read data (sign-extended halfword selected by address bit 1)
- ocupado  out  1  high in every state except OCIOSO

## Operation
- All outputs registered. Reset values: every output 0; state OCIOSO; round-robin pointer ultimo = 1, so port 0 wins the first tie.
- States: OCIOSO, ACESSO, RESPOSTA.
- OCIOSO: if no req, stay. If exactly one req, select it. If both, select the port != ultimo. Latch esc, end, wdado of the selected port; set ultimo to the selected port.
  - Address check on the latched address: error if end[0] = 1 (halfword misaligned) or end>>2 >= PALAVRAS. On error go to RESPOSTA with erro set; memory strobes stay 0.
  - Otherwise go to ACESSO.
- ACESSO (exactly one cycle): mem_endereco = latched address; mem_valor = latched data; mem_escrita = esc; mem_leitura = !esc. The memory writes wdado[15:0] on the falling edge inside this cycle. On the closing rising edge, capture mem_dado into rdadoN for reads only, drop both strobes, and go to RESPOSTA.
- RESPOSTA (one cycle): ackN = 1 for the granted port, and erroN if flagged; the other port's ack stays 0. Return to OCIOSO. rdadoN is unchanged on writes and errors.
- A requester samples ackN at the rising edge and must drop reqN after it. If reqN is still high in the following OCIOSO cycle, it is a new request.
- The non-granted request waits and is never dropped. With both ports requesting continuously, grants alternate strictly 0,1,0,1.
- mem_endereco and mem_valor return to 0 outside ACESSO.

## Timing
- Request sampled at edge N (state OCIOSO):
  - valid address: strobes high during cycle N..N+1; ackN high during N+1..N+2.
  - error: ackN + erroN high during N..N+1.
- Back-to-back throughput: one access per 3 cycles (OCIOSO→ACESSO→RESPOSTA). An error costs 2 cycles.
- A reset sampled at any edge forces OCIOSO and clears all outputs at that edge.
  - A write whose ACESSO cycle contains the falling edge is already committed and is not undone.
  - An aborted access never produces ack. The requester must re-request.
- Reset has priority over every transition, including simultaneous requests.

## Test plan
- Port 0 write end0=0x08, wdado0=0x0000_1234, then read 0x08: ack0 two cycles after sampling for each access; rdado0 = 0x0000_1234; erro0 = 0; mem_escrita high exactly one cycle.
- Port 1 write 0x0000_8001 to 0x12 (bit1=1), then read 0x12: rdado1 = 0xFFFF_8001 (sign-extended).
- req0 and req1 held high from the first cycle after reset, alternating addresses 0x00/0x04: ack order 0,1,0,1, each 3 cycles apart; ack0 and ack1 never high together.
- Port 0 read 0x100 (word 64) and read 0x05: ack0 = erro0 = 1 one cycle after sampling; mem_leitura and mem_escrita never assert; rdado0 holds its previous value.
- Reset asserted during ACESSO of a port 1 read: next cycle state OCIOSO, ocupado = 0, all outputs 0, ack1 never pulses.
- Port 1 holds req1 one extra cycle after ack1: a second, identical access is issued and acknowledged.

Source files
------------

// File: rtl/arbitro_mem_dados.sv
// arbitro_mem_dados: round-robin two-port arbiter and one-shot access sequencer for the 64-word data memory.
module arbitro_mem_dados #(
  parameter int PALAVRAS = 64,
  parameter int LARGURA  = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic               esc0,
  input  logic               esc1,
  input  logic [LARGURA-1:0] end0,
  input  logic [LARGURA-1:0] end1,
  input  logic [LARGURA-1:0] wdado0,
  input  logic [LARGURA-1:0] wdado1,
  output logic               ack0,
  output logic               ack1,
  output logic               erro0,
  output logic               erro1,
  output logic [LARGURA-1:0] rdado0,
  output logic [LARGURA-1:0] rdado1,
  output logic [LARGURA-1:0] mem_endereco,
  output logic [LARGURA-1:0] mem_valor,
  output logic               mem_escrita,
  output logic               mem_leitura,
  input  logic [LARGURA-1:0] mem_dado,
  output logic               ocupado
);
  typedef enum logic [1:0] {OCIOSO, ACESSO, RESPOSTA} estado_t;
  estado_t estado_q, estado_d;
  logic ultimo_q, ultimo_d, porta_q, porta_d, esc_q, esc_d;
  logic ack0_d, ack1_d, erro0_d, erro1_d, mem_esc_d, mem_lei_d, ocupado_d;
  logic [LARGURA-1:0] rdado0_d, rdado1_d, mem_end_d, mem_val_d;
  logic pick, s_esc, bad;
  logic [LARGURA-1:0] s_end, s_dado;
  // On a tie the port that did not win last time is chosen.
  assign pick   = (req0 && req1) ? !ultimo_q : req1;
  assign s_esc  = pick ? esc1 : esc0;
  assign s_end  = pick ? end1 : end0;
  assign s_dado = pick ? wdado1 : wdado0;
  assign bad    = s_end[0] || ((s_end >> 2) >= LARGURA'(PALAVRAS));
  always_comb begin
    estado_d  = estado_q;
    ultimo_d  = ultimo_q;
    porta_d   = porta_q;
    esc_d     = esc_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    erro0_d   = 1'b0;
    erro1_d   = 1'b0;
    rdado0_d  = rdado0;
    rdado1_d  = rdado1;
    mem_end_d = '0;
    mem_val_d = '0;
    mem_esc_d = 1'b0;
    mem_lei_d = 1'b0;
    case (estado_q)
      OCIOSO: if (req0 || req1) begin
        ultimo_d  = pick;
        porta_d   = pick;
        esc_d     = s_esc;
        estado_d  = bad ? RESPOSTA : ACESSO;
        ack0_d    = bad && !pick;
        ack1_d    = bad && pick;
        erro0_d   = bad && !pick;
        erro1_d   = bad && pick;
        mem_end_d = bad ? '0 : s_end;
        mem_val_d = bad ? '0 : s_dado;
        mem_esc_d = !bad && s_esc;
        mem_lei_d = !bad && !s_esc;
      end
      ACESSO: begin
        estado_d = RESPOSTA;
        ack0_d   = !porta_q;
        ack1_d   = porta_q;
        rdado0_d = (!esc_q && !porta_q) ? mem_dado : rdado0;
        rdado1_d = (!esc_q && porta_q) ? mem_dado : rdado1;
      end
      RESPOSTA: estado_d = OCIOSO;
      default:  estado_d = OCIOSO;
    endcase
    ocupado_d = estado_d != OCIOSO;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      ultimo_q     <= 1'b1;
      porta_q      <= 1'b0;
      esc_q        <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      erro0        <= 1'b0;
      erro1        <= 1'b0;
      rdado0       <= '0;
      rdado1       <= '0;
      mem_endereco <= '0;
      mem_valor    <= '0;
      mem_escrita  <= 1'b0;
      mem_leitura  <= 1'b0;
      ocupado      <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      ultimo_q     <= ultimo_d;
      porta_q      <= porta_d;
      esc_q        <= esc_d;
      ack0         <= ack0_d;
      ack1         <= ack1_d;
      erro0        <= erro0_d;
      erro1        <= erro1_d;
      rdado0       <= rdado0_d;
      rdado1       <= rdado1_d;
      mem_endereco <= mem_end_d;
      mem_valor    <= mem_val_d;
      mem_escrita  <= mem_esc_d;
      mem_leitura  <= mem_lei_d;
      ocupado      <= ocupado_d;
    end
  end
endmodule

// File: tb/tb_arbitro_mem_dados.sv
// tb_arbitro_mem_dados: vector table, corner sequences and random accesses against a transaction-level memory model.
module tb_arbitro_mem_dados;
  logic clock = 1'b0, reset = 1'b1;
  logic req0 = 0, req1 = 0, esc0 = 0, esc1 = 0;
  logic [31:0] end0 = 0, end1 = 0, wdado0 = 0, wdado1 = 0;
  logic ack0, ack1, erro0, erro1, mem_escrita, mem_leitura, ocupado;
  logic [31:0] rdado0, rdado1, mem_endereco, mem_valor, mem_dado;
  logic [15:0] mem [128];
  logic [15:0] ref_mem [128];
  logic [15:0] h;
  logic [31:0] exp_rd [2];
  int total = 0, bad = 0;

  arbitro_mem_dados dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .esc0(esc0), .esc1(esc1),
    .end0(end0), .end1(end1), .wdado0(wdado0), .wdado1(wdado1),
    .ack0(ack0), .ack1(ack1), .erro0(erro0), .erro1(erro1), .rdado0(rdado0), .rdado1(rdado1),
    .mem_endereco(mem_endereco), .mem_valor(mem_valor), .mem_escrita(mem_escrita),
    .mem_leitura(mem_leitura), .mem_dado(mem_dado), .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  // Halfword memory: writes on the falling edge, reads sign-extended and combinational.
  assign h = mem[mem_endereco[7:1]];
  assign mem_dado = {{16{h[15]}}, h};
  always @(negedge clock) if (mem_escrita) mem[mem_endereco[7:1]] <= mem_valor[15:0];

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, g, e, $time);
    end
  endtask

  always @(negedge clock) chk("ack_excl", {31'd0, ack0 & ack1}, 0);

  task automatic drive(input bit p, input bit r, input bit e, input logic [31:0] a, input logic [31:0] d);
    if (p) begin req1 = r; esc1 = e; end1 = a; wdado1 = d; end
    else begin req0 = r; esc0 = e; end0 = a; wdado0 = d; end
  endtask

  task automatic do_reset();
    reset = 1; req0 = 0; req1 = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
    exp_rd[0] = 0; exp_rd[1] = 0;
  endtask

  task automatic do_access(input bit p, input bit e, input logic [31:0] a, input logic [31:0] d,
                           output bit got_err, output logic [31:0] got_rd);
    int n = 0, w = 0, rc = 0;
    bit seen = 0, ee;
    drive(p, 1, e, a, d);
    while (!seen && n < 8) begin
      @(posedge clock); n++;
      @(negedge clock);
      w += int'(mem_escrita); rc += int'(mem_leitura);
      if (mem_escrita || mem_leitura) chk("mem_end", mem_endereco, a);
      else chk("mem_idle", mem_endereco | mem_valor, 0);
      if (mem_escrita) chk("mem_val", mem_valor, d);
      seen = p ? ack1 : ack0;
    end
    chk("ack_seen", {31'd0, seen}, 1);
    ee = a[0] || a > 32'hFF;
    chk("latency", n, ee ? 1 : 2);
    chk("erro", {31'd0, p ? erro1 : erro0}, {31'd0, ee});
    chk("ocupado_resp", {31'd0, ocupado}, 1);
    chk("wr_cnt", w, {31'd0, !ee && e});
    chk("rd_cnt", rc, {31'd0, !ee && !e});
    if (!ee && e) ref_mem[a[7:1]] = d[15:0];
    if (!ee && !e) exp_rd[p] = sx(ref_mem[a[7:1]]);
    got_err = p ? erro1 : erro0;
    got_rd = p ? rdado1 : rdado0;
    chk("rdado", got_rd, exp_rd[p]);
    drive(p, 0, 0, 0, 0);
    @(negedge clock);
  endtask

  typedef struct {
    bit p; bit e; logic [31:0] a; logic [31:0] d; bit err; logic [31:0] rd;
  } vec_t;
  vec_t tab [9];

  initial begin
    bit ge;
    logic [31:0] gr;
    int cnt, fa;
    int ap [$];
    int ac [$];
    tab[0] = '{0, 1, 32'h08,  32'h0000_1234, 0, 32'h0};
    tab[1] = '{0, 0, 32'h08,  32'h0,         0, 32'h0000_1234};
    tab[2] = '{1, 1, 32'h12,  32'h0000_8001, 0, 32'h0};
    tab[3] = '{1, 0, 32'h12,  32'h0,         0, 32'hFFFF_8001};
    tab[4] = '{0, 0, 32'h100, 32'h0,         1, 32'h0000_1234};
    tab[5] = '{0, 0, 32'h05,  32'h0,         1, 32'h0000_1234};
    tab[6] = '{1, 1, 32'hFE,  32'hFFFF_7FFF, 0, 32'hFFFF_8001};
    tab[7] = '{1, 0, 32'hFE,  32'h0,         0, 32'h0000_7FFF};
    tab[8] = '{1, 0, 32'hFF,  32'h0,         1, 32'h0000_7FFF};
    for (int i = 0; i < 128; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    do_reset();
    chk("rst_flags", {25'd0, ack0, ack1, erro0, erro1, mem_escrita, mem_leitura, ocupado}, 0);
    chk("rst_data", rdado0 | rdado1 | mem_endereco | mem_valor, 0);
    for (int i = 0; i < 9; i++) begin
      do_access(tab[i].p, tab[i].e, tab[i].a, tab[i].d, ge, gr);
      chk("tab_err", {31'd0, ge}, {31'd0, tab[i].err});
      chk("tab_rd", gr, tab[i].rd);
    end
    // Reset lands on the edge closing a port 1 read access.
    drive(1, 1, 0, 32'h12, 0);
    @(posedge clock); @(negedge clock);
    chk("abort_acesso", {31'd0, mem_leitura}, 1);
    reset = 1;
    @(posedge clock); @(negedge clock);
    chk("abort_flags", {25'd0, ack0, ack1, erro0, erro1, mem_escrita, mem_leitura, ocupado}, 0);
    chk("abort_data", rdado1 | mem_endereco | mem_valor, 0);
    drive(1, 0, 0, 0, 0);
    reset = 0; exp_rd[0] = 0; exp_rd[1] = 0;
    cnt = 0;
    repeat (6) begin @(posedge clock); @(negedge clock); cnt += int'(ack1); end
    chk("abort_no_ack", cnt, 0);
    // Both ports requesting continuously.
    reset = 1; repeat (2) @(posedge clock); @(negedge clock);
    reset = 0;
    drive(0, 1, 0, 32'h00, 0);
    drive(1, 1, 0, 32'h04, 0);
    for (int i = 1; i <= 13; i++) begin
      @(posedge clock); @(negedge clock);
      if (ack0) begin ap.push_back(0); ac.push_back(i); chk("rr_rd0", rdado0, sx(ref_mem[0])); end
      if (ack1) begin ap.push_back(1); ac.push_back(i); chk("rr_rd1", rdado1, sx(ref_mem[2])); end
    end
    chk("rr_count", ap.size(), 4);
    for (int i = 0; i < ap.size(); i++) begin
      chk("rr_order", ap[i], i % 2);
      chk("rr_spacing", ac[i], 2 + 3 * i);
    end
    do_reset();
    // Port 1 keeps req1 for one extra edge after ack1.
    drive(1, 1, 0, 32'h12, 0);
    cnt = 0; fa = -10;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clock); @(negedge clock);
      if (ack1) begin
        cnt++;
        if (cnt == 1) fa = i;
        chk("hold_rd", rdado1, sx(ref_mem[9]));
      end
      if (i == fa + 2) drive(1, 0, 0, 0, 0);
    end
    chk("hold_count", cnt, 2);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 7);
      a = r == 0 ? $urandom_range(256, 400) : r == 1 ? (($urandom % 256) | 1) : (($urandom % 32) << 1);
      do_access(1'($urandom % 2), 1'($urandom % 2), a, $urandom, ge, gr);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
